// File: rtl/axis_dispatch_sched_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | axis_dispatch_sched_pkg                                          |
// | Shared FSM states and round-robin search helper for the packet   |
// | dispatcher.                                                      |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
package axis_dispatch_sched_pkg;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_PKT  = 1'b1
  } sched_state_t;

  localparam int unsigned C_RR_MAX_PORTS = 32;
  localparam int unsigned C_RR_IDX_W     = 5;

  typedef struct packed {
    logic                  found;
    logic [C_RR_IDX_W-1:0] idx;
  } rr_pick_t;

  // Search starts one past last_grant and wraps at num_ports; the first set mask bit wins.
  function automatic rr_pick_t rr_first_eligible(
    input logic [C_RR_MAX_PORTS-1:0] mask,
    input logic [C_RR_IDX_W-1:0]     last_grant,
    input int unsigned               num_ports
  );
    rr_pick_t    res;
    int unsigned cand;
    res.found = 1'b0;
    res.idx   = '0;
    for (int unsigned k = 1; k <= C_RR_MAX_PORTS; k++) begin
      cand = 32'(last_grant) + k;
      if (cand >= num_ports) cand = cand - num_ports;
      if ((k <= num_ports) && !res.found && mask[cand[C_RR_IDX_W-1:0]]) begin
        res.found = 1'b1;
        res.idx   = cand[C_RR_IDX_W-1:0];
      end
    end
    return res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/axis_dispatch_sched_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | axis_dispatch_sched_if                                           |
// | Input stream, fanned-out worker streams and order stream.        |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
interface axis_dispatch_sched_if #(
  parameter int DATA_W    = 64,
  parameter int USER_W    = 1,
  parameter int NUM_PORTS = 4
);
  localparam int IDX_W = $clog2(NUM_PORTS);

  logic [DATA_W-1:0]                  i_tdata;
  logic [USER_W-1:0]                  i_tuser;
  logic                               i_tlast;
  logic                               i_tvalid;
  logic                               i_tready;

  logic [NUM_PORTS-1:0][DATA_W-1:0]   o_tdata;
  logic [NUM_PORTS-1:0][USER_W-1:0]   o_tuser;
  logic [NUM_PORTS-1:0]               o_tlast;
  logic [NUM_PORTS-1:0]               o_tvalid;
  logic [NUM_PORTS-1:0]               o_tready;

  logic [IDX_W-1:0]                   ord_tdata;
  logic                               ord_tvalid;
  logic                               ord_tready;

  modport master (
    output i_tdata, i_tuser, i_tlast, i_tvalid, o_tready, ord_tready,
    input  i_tready, o_tdata, o_tuser, o_tlast, o_tvalid, ord_tdata, ord_tvalid
  );

  modport slave (
    input  i_tdata, i_tuser, i_tlast, i_tvalid, o_tready, ord_tready,
    output i_tready, o_tdata, o_tuser, o_tlast, o_tvalid, ord_tdata, ord_tvalid
  );

endinterface
`default_nettype wire

// File: rtl/axi_fifo.sv
`default_nettype none
// +------------------------------------------------------------------+
// | axi_fifo                                                         |
// | Synchronous valid/ready FIFO of 2**SIZE entries, async reset.    |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module axi_fifo #(
  parameter int WIDTH = 8,
  parameter int SIZE  = 4
) (
  input  wire logic             clk,
  input  wire logic             rst,
  input  wire logic [WIDTH-1:0] s_tdata,
  input  wire logic             s_tvalid,
  output logic                  s_tready,
  output logic [WIDTH-1:0]      m_tdata,
  output logic                  m_tvalid,
  input  wire logic             m_tready
);
  localparam int DEPTH = 1 << SIZE;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [SIZE:0]    wr_q, rd_q;
  logic             push, pop;

  // Pointers carry one extra bit so full and empty are distinguishable.
  assign s_tready = (wr_q - rd_q) != (SIZE+1)'(DEPTH);
  assign m_tvalid = (wr_q != rd_q);
  assign m_tdata  = mem_q[rd_q[SIZE-1:0]];
  assign push     = s_tvalid && s_tready;
  assign pop      = m_tvalid && m_tready;

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q[SIZE-1:0]] <= s_tdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (push) wr_q <= wr_q + 1'b1;
      if (pop)  rd_q <= rd_q + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/axis_dispatch_sched_credit.sv
`default_nettype none
// +------------------------------------------------------------------+
// | axis_dispatch_credit                                             |
// | Per-worker credit counter with sticky overflow and busy flag.    |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module axis_dispatch_credit #(
  parameter int MAX_CREDITS = 2,
  parameter int CNT_W       = $clog2(MAX_CREDITS + 1)
) (
  input  wire logic             clk,
  input  wire logic             rst_n,
  input  wire logic             grant_i,
  input  wire logic             done_i,
  output logic [CNT_W-1:0]      credit_o,
  output logic                  busy_o,
  output logic                  err_o
);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(MAX_CREDITS);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q;
  logic             err_q, err_d;

  // A grant is only issued while credit is nonzero, so the decrement cannot underflow.
  always_comb begin
    cnt_d = cnt_q;
    err_d = err_q;
    case ({grant_i, done_i})
      2'b10:   cnt_d = cnt_q - 1'b1;
      2'b01: begin
        if (cnt_q == FULL) err_d = 1'b1;
        else               cnt_d = cnt_q + 1'b1;
      end
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= FULL;
      busy_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      busy_q <= (cnt_d == '0);
      err_q  <= err_d;
    end
  end

  assign credit_o = cnt_q;
  assign busy_o   = busy_q;
  assign err_o    = err_q;

endmodule
`default_nettype wire

// File: rtl/axis_dispatch_sched.sv
`default_nettype none
// +------------------------------------------------------------------+
// | axis_dispatch_sched                                              |
// | Round-robin, credit-gated whole-packet dispatcher with order log.|
// | Optional AXIS_DISPATCH_SCHED_STATS_EN adds per-worker counters.  |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module axis_dispatch_sched
  import axis_dispatch_sched_pkg::*;
#(
  parameter int DATA_W        = 64,
  parameter int USER_W        = 1,
  parameter int NUM_PORTS     = 4,
  parameter int MAX_CREDITS   = 2,
  parameter int ORD_FIFO_SIZE = 5
) (
  input  wire logic                   clk,
  input  wire logic                   rst_n,
  axis_dispatch_sched_if.slave        bus,
  input  wire logic [NUM_PORTS-1:0]   i_done,
  output logic [NUM_PORTS-1:0]        busy,
  output logic                        err,
  output logic [NUM_PORTS-1:0][31:0]  stat_pkts
);
  localparam int IDX_W = $clog2(NUM_PORTS);
  localparam int CNT_W = $clog2(MAX_CREDITS + 1);

  sched_state_t                    state_q, state_d;
  logic [IDX_W-1:0]                sel_q, sel_d;
  logic [IDX_W-1:0]                last_q, last_d;
  logic [NUM_PORTS-1:0]            grant, eligible, port_err;
  logic [NUM_PORTS-1:0][CNT_W-1:0] credit;
  logic [C_RR_MAX_PORTS-1:0]       rr_mask;
  logic [C_RR_IDX_W-1:0]           rr_last;
  rr_pick_t                        rr;
  logic                            ord_push, ord_room;

  always_comb begin
    rr_mask                  = '0;
    rr_mask[NUM_PORTS-1:0]   = eligible;
    rr_last                  = '0;
    rr_last[IDX_W-1:0]       = last_q;
    rr = rr_first_eligible(rr_mask, rr_last, unsigned'(NUM_PORTS));
  end

  always_comb begin
    state_d       = state_q;
    sel_d         = sel_q;
    last_d        = last_q;
    grant         = '0;
    ord_push      = 1'b0;
    bus.i_tready  = 1'b0;
    bus.o_tvalid  = '0;
    case (state_q)
      ST_IDLE: begin
        if (bus.i_tvalid && rr.found && ord_room) begin
          sel_d        = rr.idx[IDX_W-1:0];
          last_d       = rr.idx[IDX_W-1:0];
          grant[sel_d] = 1'b1;
          ord_push     = 1'b1;
          state_d      = ST_PKT;
        end
      end
      ST_PKT: begin
        // Locked to sel_q until tlast is accepted, however long the worker stalls.
        bus.o_tvalid[sel_q] = bus.i_tvalid;
        bus.i_tready        = bus.o_tready[sel_q];
        if (bus.i_tvalid && bus.o_tready[sel_q] && bus.i_tlast) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      sel_q   <= '0;
      last_q  <= IDX_W'(NUM_PORTS - 1);
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
    end
  end

  assign bus.o_tdata = {NUM_PORTS{bus.i_tdata}};
  assign bus.o_tuser = {NUM_PORTS{bus.i_tuser}};
  assign bus.o_tlast = {NUM_PORTS{bus.i_tlast}};

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_credit
    axis_dispatch_credit #(
      .MAX_CREDITS (MAX_CREDITS),
      .CNT_W       (CNT_W)
    ) u_credit (
      .clk      (clk),
      .rst_n    (rst_n),
      .grant_i  (grant[p]),
      .done_i   (i_done[p]),
      .credit_o (credit[p]),
      .busy_o   (busy[p]),
      .err_o    (port_err[p])
    );
    assign eligible[p] = (credit[p] != '0);
  end

  assign err = |port_err;

  axi_fifo #(
    .WIDTH (IDX_W),
    .SIZE  (ORD_FIFO_SIZE)
  ) u_ord_fifo (
    .clk      (clk),
    .rst      (!rst_n),
    .s_tdata  (sel_d),
    .s_tvalid (ord_push),
    .s_tready (ord_room),
    .m_tdata  (bus.ord_tdata),
    .m_tvalid (bus.ord_tvalid),
    .m_tready (bus.ord_tready)
  );

`ifdef AXIS_DISPATCH_SCHED_STATS_EN
  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_stat
    logic [31:0] pkts_q;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)        pkts_q <= '0;
      else if (grant[p]) pkts_q <= pkts_q + 32'd1;
    end
    assign stat_pkts[p] = pkts_q;
  end
`else
  assign stat_pkts = '0;
`endif

endmodule
`default_nettype wire
